dm_access_ctrl: RTL and testbench

Memory-stage access controller between the pipeline's MEM stage and the word-only data memory, which has a 32-bit word write port and a combinational read port. It decodes load/store ops and checks alignment and address range. Loads are extracted and extended combinationally. Byte and halfword stores run as a two-cycle read-modify-write, and the controller stalls the pipeline for one cycle while doing so.

---
 rtl/mem_ops_pkg.sv | 47 ++++
 rtl/dm_load_ext.sv | 37 +++
 rtl/dm_access_ctrl.sv | 114 +++++++++++
 tb/tb_dm_access_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ops_pkg.sv
// ============================================================================
// Module  : mem_ops_pkg
// Brief   : Memory op codes, access-controller FSM encoding and lane helpers.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_ops_pkg;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LW   = 4'd1;
   localparam logic [3:0] OP_LH   = 4'd2;
   localparam logic [3:0] OP_LHU  = 4'd3;
   localparam logic [3:0] OP_LB   = 4'd4;
   localparam logic [3:0] OP_LBU  = 4'd5;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [3:0] OP_SH   = 4'd9;
   localparam logic [3:0] OP_SB   = 4'd10;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_MERGE = 1'b1
   } state_e;

   // Replace one byte or halfword lane of a little-endian word.
   function automatic logic [WORD_W-1:0] merge_lane(
      input logic [WORD_W-1:0] old_w,
      input logic [WORD_W-1:0] src,
      input logic              is_half,
      input logic [1:0]        off
   );
      logic [WORD_W-1:0] r;
      r = old_w;
      if (is_half)
         r[{off[1], 4'b0000} +: HALF_W] = src[HALF_W-1:0];
      else
         r[{off, 3'b000} +: BYTE_W] = src[BYTE_W-1:0];
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dm_load_ext.sv
// ============================================================================
// Module  : dm_load_ext
// Brief   : Load lane select with sign/zero extension.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dm_load_ext
   import mem_ops_pkg::*;
(
   input  logic [3:0]        i_op,
   input  logic [1:0]        i_off,
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_data
);

   logic [BYTE_W-1:0] w_byte;
   logic [HALF_W-1:0] w_half;

   assign w_byte = i_word[{i_off, 3'b000} +: BYTE_W];
   assign w_half = i_word[{i_off[1], 4'b0000} +: HALF_W];

   always_comb begin
      o_data = '0;
      case (i_op)
         OP_LW:   o_data = i_word;
         OP_LH:   o_data = {{(WORD_W-HALF_W){w_half[HALF_W-1]}}, w_half};
         OP_LHU:  o_data = {{(WORD_W-HALF_W){1'b0}}, w_half};
         OP_LB:   o_data = {{(WORD_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
         OP_LBU:  o_data = {{(WORD_W-BYTE_W){1'b0}}, w_byte};
         default: o_data = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dm_access_ctrl.sv
// ============================================================================
// Module  : dm_access_ctrl
// Brief   : MEM-stage data-memory controller with partial-store read-modify-write.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module dm_access_ctrl
   import mem_ops_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic [3:0]  op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] pc_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        exc_adel_o,
   output logic        exc_ades_o,
   output logic [31:0] dm_a_o,
   output logic        dm_we_o,
   output logic [31:0] dm_wd_o,
   output logic [31:0] dm_pc_o,
   input  logic [31:0] dm_rd_i
);

   state_e      r_state;
   state_e      w_next;
   logic [31:0] r_old;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_word;
   logic        w_is_half;
   logic        w_is_part;
   logic        w_bad;
   logic        w_ok;
   logic [31:0] w_ext;

   assign w_is_load  = (op_i == OP_LW) || (op_i == OP_LH) || (op_i == OP_LHU) ||
                       (op_i == OP_LB) || (op_i == OP_LBU);
   assign w_is_store = (op_i == OP_SW) || (op_i == OP_SH) || (op_i == OP_SB);
   assign w_is_word  = (op_i == OP_LW) || (op_i == OP_SW);
   assign w_is_half  = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
   assign w_is_part  = (op_i == OP_SH) || (op_i == OP_SB);

   assign w_bad = valid_i && (w_is_load || w_is_store) &&
                  ((w_is_word && (addr_i[1:0] != 2'b00)) ||
                   (w_is_half && addr_i[0]) ||
                   (addr_i >= ADDR_LIMIT));
   assign w_ok  = valid_i && !w_bad;

   assign exc_adel_o = w_bad && w_is_load;
   assign exc_ades_o = w_bad && w_is_store;
   assign dm_a_o     = {addr_i[31:2], 2'b00};
   assign dm_pc_o    = pc_i;

   dm_load_ext u_load_ext (
      .i_op   (op_i),
      .i_off  (addr_i[1:0]),
      .i_word (dm_rd_i),
      .o_data (w_ext)
   );

   assign rdata_o = (w_is_load && !w_bad) ? w_ext : 32'h0;

   always_comb begin
      w_next  = r_state;
      stall_o = 1'b0;
      dm_we_o = 1'b0;
      dm_wd_o = wdata_i;
      case (r_state)
         ST_IDLE: begin
            if (w_ok && w_is_part) begin
               stall_o = 1'b1;
               w_next  = ST_MERGE;
            end else if (w_ok && (op_i == OP_SW)) begin
               dm_we_o = 1'b1;
            end
         end
         ST_MERGE: begin
            // Dropped valid or a changed op aborts the pending write.
            w_next = ST_IDLE;
            if (w_ok && w_is_part) begin
               dm_we_o = 1'b1;
               dm_wd_o = merge_lane(r_old, wdata_i, op_i == OP_SH, addr_i[1:0]);
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (reset) begin
         stall_o = 1'b0;
         dm_we_o = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_old   <= 32'h0;
      end else begin
         r_state <= w_next;
         if ((r_state == ST_IDLE) && (w_next == ST_MERGE))
            r_old <= dm_rd_i;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
// ============================================================================
// Module  : tb_dm_access_ctrl
// Brief   : Directed scoreboard bench for dm_access_ctrl with a word memory model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [3:0]  op_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] pc_i;
   logic        stall_o;
   logic [31:0] rdata_o;
   logic        exc_adel_o;
   logic        exc_ades_o;
   logic [31:0] dm_a_o;
   logic        dm_we_o;
   logic [31:0] dm_wd_o;
   logic [31:0] dm_pc_o;
   logic [31:0] dm_rd_i;

   logic [31:0] mem [0:3071];
   logic [31:0] exp_q [$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          stall_cnt;

   always #5 clk = ~clk;

   dm_access_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (valid_i),
      .op_i       (op_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .pc_i       (pc_i),
      .stall_o    (stall_o),
      .rdata_o    (rdata_o),
      .exc_adel_o (exc_adel_o),
      .exc_ades_o (exc_ades_o),
      .dm_a_o     (dm_a_o),
      .dm_we_o    (dm_we_o),
      .dm_wd_o    (dm_wd_o),
      .dm_pc_o    (dm_pc_o),
      .dm_rd_i    (dm_rd_i)
   );

   assign dm_rd_i = (dm_a_o < 32'h3000) ? mem[dm_a_o[13:2]] : 32'h0;

   always @(posedge clk)
      if (dm_we_o && (dm_a_o < 32'h3000))
         mem[dm_a_o[13:2]] <= dm_wd_o;

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd);
      valid_i = v;
      op_i    = op;
      addr_i  = a;
      wdata_i = wd;
      pc_i    = 32'h0040_0000 + a;
      #3;
   endtask

   initial begin
      for (int i = 0; i < 3072; i++) mem[i] = 32'h0;
      mem[32'h10 >> 2] = 32'h8070_60F0;
      mem[32'h30 >> 2] = 32'h1111_1111;
      mem[32'h50 >> 2] = 32'hFFFF_FFFF;
      mem[32'h60 >> 2] = 32'h1357_2468;
      reset = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      tick();
      tick();
      push(32'h0); check("reset_stall", {31'h0, stall_o});
      push(32'h0); check("reset_we", {31'h0, dm_we_o});

      reset = 1'b0;
      tick();
      drive(1'b1, 4'd4, 32'h10, 32'h0);
      push(32'hFFFF_FFF0); check("lb_sign", rdata_o);
      push(32'h0040_0010); check("pc_pass", dm_pc_o);
      push(32'h0000_0010); check("dm_addr", dm_a_o);
      tick(); drive(1'b1, 4'd5, 32'h13, 32'h0);
      push(32'h0000_0080); check("lbu_zero", rdata_o);
      tick(); drive(1'b1, 4'd2, 32'h12, 32'h0);
      push(32'hFFFF_8070); check("lh_sign", rdata_o);
      push(32'h0); check("lh_stall", {31'h0, stall_o});
      tick(); drive(1'b1, 4'd3, 32'h12, 32'h0);
      push(32'h0000_8070); check("lhu_zero", rdata_o);
      tick(); drive(1'b1, 4'd1, 32'h10, 32'h0);
      push(32'h8070_60F0); check("lw", rdata_o);

      tick(); drive(1'b1, 4'd8, 32'h20, 32'h1234_5678);
      push(32'h1); check("sw_we", {31'h0, dm_we_o});
      push(32'h0); check("sw_stall", {31'h0, stall_o});
      push(32'h1234_5678); check("sw_wd", dm_wd_o);
      tick(); drive(1'b0, 4'd0, 32'h0, 32'h0);
      push(32'h1234_5678); check("sw_mem", mem[32'h20 >> 2]);

      tick(); drive(1'b1, 4'd10, 32'h31, 32'h0000_00AB);
      push(32'h1); check("sb_c0_stall", {31'h0, stall_o});
      push(32'h0); check("sb_c0_we", {31'h0, dm_we_o});
      tick(); #3;
      push(32'h0); check("sb_c1_stall", {31'h0, stall_o});
      push(32'h1); check("sb_c1_we", {31'h0, dm_we_o});
      push(32'h1111_AB11); check("sb_c1_wd", dm_wd_o);
      tick(); drive(1'b0, 4'd0, 32'h0, 32'h0);
      push(32'h1111_AB11); check("sb_mem", mem[32'h30 >> 2]);

      tick(); drive(1'b1, 4'd9, 32'h41, 32'h0000_BEEF);
      push(32'h1); check("sh_mis_ades", {31'h0, exc_ades_o});
      push(32'h0); check("sh_mis_we", {31'h0, dm_we_o});
      push(32'h0); check("sh_mis_stall", {31'h0, stall_o});
      push(32'h0); check("sh_mis_adel", {31'h0, exc_adel_o});
      tick(); drive(1'b1, 4'd1, 32'h42, 32'h0);
      push(32'h1); check("lw_mis_adel", {31'h0, exc_adel_o});
      push(32'h0); check("lw_mis_rdata", rdata_o);
      tick(); drive(1'b1, 4'd1, 32'h3000, 32'h0);
      push(32'h1); check("lw_range_adel", {31'h0, exc_adel_o});
      tick(); drive(1'b1, 4'd1, 32'h2FFC, 32'h0);
      push(32'h0); check("lw_last_adel", {31'h0, exc_adel_o});
      tick(); drive(1'b0, 4'd1, 32'h3000, 32'h0);
      push(32'h0); check("invalid_no_exc", {31'h0, exc_adel_o});
      tick(); drive(1'b1, 4'd7, 32'h20, 32'h0);
      push(32'h0); check("bad_op_we", {30'h0, dm_we_o, stall_o});

      stall_cnt = 0;
      tick(); drive(1'b1, 4'd10, 32'h50, 32'h0000_0000);
      stall_cnt += int'(stall_o);
      tick(); #3;
      stall_cnt += int'(stall_o);
      push(32'hFFFF_FF00); check("b2b_wd1", dm_wd_o);
      tick(); drive(1'b1, 4'd10, 32'h52, 32'h0000_00CC);
      stall_cnt += int'(stall_o);
      tick(); #3;
      stall_cnt += int'(stall_o);
      push(32'hFFCC_FF00); check("b2b_wd2", dm_wd_o);
      tick(); drive(1'b1, 4'd1, 32'h50, 32'h0);
      push(32'hFFCC_FF00); check("b2b_load_after", rdata_o);
      push(32'hFFCC_FF00); check("b2b_mem", mem[32'h50 >> 2]);
      push(32'd2); check("b2b_stalls", stall_cnt);

      tick(); drive(1'b1, 4'd9, 32'h60, 32'h0000_BEEF);
      push(32'h1); check("rst_sh_c0_stall", {31'h0, stall_o});
      tick();
      reset = 1'b1;
      #3;
      push(32'h0); check("rst_merge_we", {31'h0, dm_we_o});
      tick();
      reset = 1'b0;
      #3;
      push(32'h1); check("rst_idle_stall", {31'h0, stall_o});
      push(32'h0); check("rst_idle_we", {31'h0, dm_we_o});
      push(32'h1357_2468); check("rst_mem_kept", mem[32'h60 >> 2]);
      tick(); drive(1'b0, 4'd0, 32'h0, 32'h0);
      push(32'h0); check("abort_we", {31'h0, dm_we_o});
      tick(); #3;
      push(32'h1357_2468); check("abort_mem", mem[32'h60 >> 2]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
